// File: rtl/exec_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
// Shared types for the RV32IM execute stage: the packed control word carried
// from decode, ALU opcodes, RV32M operation codes (funct3 encoding), the
// multiply/divide FSM state encoding and branch condition classes.
// -----------------------------------------------------------------------------
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLT    = 4'd5,
        ALU_SLTU   = 4'd6,
        ALU_SLL    = 4'd7,
        ALU_SRL    = 4'd8,
        ALU_SRA    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    // Matches RV32M funct3: bit 2 selects divide, bit 0 selects unsigned
    // for divides, bit 1 selects remainder for divides.
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    typedef enum logic [1:0] {
        BR_EQ  = 2'd0,
        BR_LT  = 2'd1,
        BR_LTU = 2'd2
    } br_cond_e;

    typedef struct packed {
        alu_op_e     alu_control;
        logic        alu_src;
        logic        a_sel_pc;
        logic        md_en;
        md_op_e      md_op;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        funct3_0;
        logic        reg_write;
        logic        result_src;
        logic        mem_write;
        logic [4:0]  rd;
    } exec_ctrl_t;

    // Decode drives the compare flavour through alu_control: SUB for
    // beq/bne, SLT for blt/bge, SLTU for bltu/bgeu.
    function automatic br_cond_e br_cond_of(input alu_op_e op);
        case (op)
            ALU_SLT:  return BR_LT;
            ALU_SLTU: return BR_LTU;
            default:  return BR_EQ;
        endcase
    endfunction

endpackage

// File: rtl/exec_md_stage_md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
// Iterative RV32M multiply/divide unit. A pipelined multiplier of depth
// MUL_LATENCY and a radix-2 restoring divider on operand magnitudes, with the
// divide-by-zero and signed-overflow cases resolved in the start cycle.
// Optional feature macro: EXEC_DIV_EARLY_OUT_EN (|dividend| < |divisor|
// finishes in the start cycle).
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         new M instruction presented (already gated by flush)
//   flush         abort any operation in progress
//   op_a, op_b    operands (dividend / divisor for divides)
//   md_op         RV32M operation
//   result        selected M result, meaningful while done=1
//   done          result valid this cycle
//   busy          stage must hold the front end this cycle
// -----------------------------------------------------------------------------
//   state   | meaning
//   IDLE    | waiting; a start latches operands and asserts busy
//   MUL     | multiplier pipeline filling, MUL_LATENCY cycles
//   DIV     | one restoring-division step per cycle, XLEN cycles
//   DONE    | result presented for one cycle, back to IDLE
// -----------------------------------------------------------------------------
module md_unit
    import exec_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  md_op_e          md_op,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy
);

    localparam int CNT_MAX = (XLEN > MUL_LATENCY) ? XLEN : MUL_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e          state, state_n;
    md_op_e             op_q;
    logic [XLEN-1:0]    a_q, b_q;
    logic [XLEN-1:0]    quo_q, rem_q, div_q;
    logic               neg_quo_q, neg_rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*XLEN-1:0]  prod_pipe [MUL_LATENCY];

    logic               start_ok;
    logic               sign_div, a_neg, b_neg;
    logic [XLEN-1:0]    a_mag, b_mag;
    logic               div_zero, div_ovf, div_early, div_special;
    logic [XLEN-1:0]    special_quo, special_rem;

    assign start_ok = start & ~flush & ~rst;

    // Start-cycle operand analysis for divides.
    assign sign_div = ~md_op[0];
    assign a_neg    = sign_div & op_a[XLEN-1];
    assign b_neg    = sign_div & op_b[XLEN-1];
    assign a_mag    = a_neg ? -op_a : op_a;
    assign b_mag    = b_neg ? -op_b : op_b;
    assign div_zero = (op_b == '0);
    assign div_ovf  = sign_div & (op_a == MOST_NEG) & (op_b == '1);
`ifdef EXEC_DIV_EARLY_OUT_EN
    assign div_early = ~div_zero & (a_mag < b_mag);
`else
    assign div_early = 1'b0;
`endif
    assign div_special = div_zero | div_ovf | div_early;

    // Special results are stored pre-signed, so the sign fix-up is disabled.
    assign special_quo = div_zero ? '1   : (div_ovf ? op_a : '0);
    assign special_rem = div_zero ? op_a : (div_ovf ? '0   : op_a);

    // Divider step.
    logic [XLEN:0]   rem_shift;
    logic            rem_ge;
    logic [XLEN-1:0] rem_diff;

    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign rem_ge    = (rem_shift >= {1'b0, div_q});
    assign rem_diff  = rem_shift[XLEN-1:0] - div_q;

    // Multiplier operands, sign-extended to 2*XLEN so one product covers all
    // four signedness combinations.
    logic               mul_sa, mul_sb;
    logic [2*XLEN-1:0]  mul_a_ext, mul_b_ext, mul_prod;

    assign mul_sa    = (op_q != MD_MULHU);
    assign mul_sb    = (op_q == MD_MUL) | (op_q == MD_MULH);
    assign mul_a_ext = {{XLEN{mul_sa & a_q[XLEN-1]}}, a_q};
    assign mul_b_ext = {{XLEN{mul_sb & b_q[XLEN-1]}}, b_q};
    assign mul_prod  = mul_a_ext * mul_b_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    busy = 1'b1;
                    if (!md_op[2])        state_n = ST_MUL;
                    else if (div_special) state_n = ST_DONE;
                    else                  state_n = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                busy = 1'b1;
                if (cnt_q == '0) state_n = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        if (flush || rst) begin
            busy    = 1'b0;
            done    = 1'b0;
            state_n = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= MD_MUL;
            a_q       <= '0;
            b_q       <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
        end else if (state == ST_IDLE) begin
            if (start_ok) begin
                op_q  <= md_op;
                a_q   <= op_a;
                b_q   <= op_b;
                div_q <= b_mag;
                cnt_q <= md_op[2] ? DIV_LOAD : MUL_LOAD;
                if (div_special) begin
                    quo_q     <= special_quo;
                    rem_q     <= special_rem;
                    neg_quo_q <= 1'b0;
                    neg_rem_q <= 1'b0;
                end else begin
                    quo_q     <= a_mag;
                    rem_q     <= '0;
                    neg_quo_q <= a_neg ^ b_neg;
                    neg_rem_q <= a_neg;
                end
            end
        end else if (state == ST_DIV) begin
            quo_q <= {quo_q[XLEN-2:0], rem_ge};
            rem_q <= rem_ge ? rem_diff : rem_shift[XLEN-1:0];
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end else if (state == ST_MUL) begin
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_LATENCY; i++) prod_pipe[i] <= '0;
        end else begin
            prod_pipe[0] <= mul_prod;
            for (int i = 1; i < MUL_LATENCY; i++) prod_pipe[i] <= prod_pipe[i-1];
        end
    end

    logic [2*XLEN-1:0] prod_out;
    logic [XLEN-1:0]   mul_res, quotient, remainder;

    assign prod_out  = prod_pipe[MUL_LATENCY-1];
    assign mul_res   = (op_q == MD_MUL) ? prod_out[XLEN-1:0] : prod_out[2*XLEN-1:XLEN];
    assign quotient  = neg_quo_q ? -quo_q : quo_q;
    assign remainder = neg_rem_q ? -rem_q : rem_q;
    assign result    = !op_q[2] ? mul_res : (op_q[1] ? remainder : quotient);

endmodule

// File: rtl/exec_md_stage.sv
// -----------------------------------------------------------------------------
// exec_md_stage
// RV32IM execute stage: operand forwarding muxes, single-cycle ALU, branch and
// jump resolution, and an iterative multiply/divide unit (md_unit) that holds
// the front end through stall_e while it works.
// Optional feature macro: EXEC_DIV_EARLY_OUT_EN (see md_unit).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   valid_d, flush_e          instruction present / kill it
//   pc_d, rd1_d, rd2_d        PC and register-file operands
//   imm_ext_d, ctrl_d         immediate and packed control word
//   fwd_sel_a/b, fwd_data     bypass selects (0 = regfile) and bypass values
//   result_e, write_data_e    ALU/M result, store data (forwarded operand B)
//   data_addr                 src_a + immediate
//   pc_target_e, pc_src_e     branch/jump target and redirect
//   valid_e, ctrl_e           result valid, control passed through
//   stall_e                   hold fetch/decode and the decode/exec register
// -----------------------------------------------------------------------------
module exec_md_stage
    import exec_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_FWD     = 3,
    parameter int MUL_LATENCY = 2,
    localparam int SEL_W      = $clog2(NUM_FWD + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_d,
    input  logic                    flush_e,
    input  logic [XLEN-1:0]         pc_d,
    input  logic [XLEN-1:0]         rd1_d,
    input  logic [XLEN-1:0]         rd2_d,
    input  logic [XLEN-1:0]         imm_ext_d,
    input  exec_ctrl_t              ctrl_d,
    input  logic [SEL_W-1:0]        fwd_sel_a,
    input  logic [SEL_W-1:0]        fwd_sel_b,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    output logic [XLEN-1:0]         result_e,
    output logic [XLEN-1:0]         write_data_e,
    output logic [XLEN-1:0]         data_addr,
    output logic [XLEN-1:0]         pc_target_e,
    output logic                    pc_src_e,
    output logic                    valid_e,
    output exec_ctrl_t              ctrl_e,
    output logic                    stall_e
);

    localparam int SHAMT_W = $clog2(XLEN);

    logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b;

    // Selects beyond NUM_FWD fall through to zero.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        if (fwd_sel_a == '0) fwd_a = rd1_d;
        if (fwd_sel_b == '0) fwd_b = rd2_d;
        for (int k = 1; k <= NUM_FWD; k++) begin
            if (fwd_sel_a == SEL_W'(k)) fwd_a = fwd_data[k*XLEN-1 -: XLEN];
            if (fwd_sel_b == SEL_W'(k)) fwd_b = fwd_data[k*XLEN-1 -: XLEN];
        end
    end

    assign src_a        = ctrl_d.a_sel_pc ? pc_d : fwd_a;
    assign src_b        = ctrl_d.alu_src ? imm_ext_d : fwd_b;
    assign write_data_e = fwd_b;
    assign data_addr    = src_a + imm_ext_d;

    logic               lt_s, lt_u;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    alu_res;

    assign lt_s  = $signed(src_a) < $signed(src_b);
    assign lt_u  = src_a < src_b;
    assign shamt = src_b[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        case (ctrl_d.alu_control)
            ALU_ADD:    alu_res = src_a + src_b;
            ALU_SUB:    alu_res = src_a - src_b;
            ALU_AND:    alu_res = src_a & src_b;
            ALU_OR:     alu_res = src_a | src_b;
            ALU_XOR:    alu_res = src_a ^ src_b;
            ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, lt_u};
            ALU_SLL:    alu_res = src_a << shamt;
            ALU_SRL:    alu_res = src_a >> shamt;
            ALU_SRA:    alu_res = $signed(src_a) >>> shamt;
            ALU_PASS_B: alu_res = src_b;
            default:    alu_res = '0;
        endcase
    end

    logic br_met, br_raw;
    logic [XLEN-1:0] jalr_sum;

    always_comb begin
        case (br_cond_of(ctrl_d.alu_control))
            BR_LT:   br_raw = lt_s;
            BR_LTU:  br_raw = lt_u;
            default: br_raw = (src_a == src_b);
        endcase
    end

    // funct3[0] turns beq/blt/bltu into bne/bge/bgeu.
    assign br_met      = br_raw ^ ctrl_d.funct3_0;
    assign jalr_sum    = src_a + imm_ext_d;
    assign pc_target_e = ctrl_d.jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_d + imm_ext_d;
    assign pc_src_e    = valid_d & ~flush_e & ~rst
                         & ((ctrl_d.branch & br_met) | ctrl_d.jump);

    logic            md_done, md_busy;
    logic [XLEN-1:0] md_res;

    md_unit #(
        .XLEN        (XLEN),
        .MUL_LATENCY (MUL_LATENCY)
    ) u_md (
        .clk    (clk),
        .rst    (rst),
        .start  (valid_d & ctrl_d.md_en & ~flush_e),
        .flush  (flush_e),
        .op_a   (src_a),
        .op_b   (src_b),
        .md_op  (ctrl_d.md_op),
        .result (md_res),
        .done   (md_done),
        .busy   (md_busy)
    );

    assign result_e = ctrl_d.md_en ? md_res : alu_res;
    assign valid_e  = ctrl_d.md_en ? md_done : (valid_d & ~flush_e & ~rst);
    assign stall_e  = md_busy;
    assign ctrl_e   = ctrl_d;

endmodule

// File: tb/tb_exec_md_stage.sv
module tb_exec_md_stage;
    import exec_pkg::*;

    localparam int XLEN    = 32;
    localparam int NUM_FWD = 3;
    localparam int SEL_W   = 2;

`ifdef EXEC_DIV_EARLY_OUT_EN
    localparam int EARLY_STALL = 1;
`else
    localparam int EARLY_STALL = 33;
`endif

    logic                    clk;
    logic                    rst;
    logic                    valid_d;
    logic                    flush_e;
    logic [XLEN-1:0]         pc_d, rd1_d, rd2_d, imm_ext_d;
    exec_ctrl_t              ctrl_d;
    logic [SEL_W-1:0]        fwd_sel_a, fwd_sel_b;
    logic [NUM_FWD*XLEN-1:0] fwd_data;
    logic [XLEN-1:0]         result_e, write_data_e, data_addr, pc_target_e;
    logic                    pc_src_e, valid_e, stall_e;
    exec_ctrl_t              ctrl_e;

    exec_md_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .MUL_LATENCY(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_d      (valid_d),
        .flush_e      (flush_e),
        .pc_d         (pc_d),
        .rd1_d        (rd1_d),
        .rd2_d        (rd2_d),
        .imm_ext_d    (imm_ext_d),
        .ctrl_d       (ctrl_d),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .fwd_data     (fwd_data),
        .result_e     (result_e),
        .write_data_e (write_data_e),
        .data_addr    (data_addr),
        .pc_target_e  (pc_target_e),
        .pc_src_e     (pc_src_e),
        .valid_e      (valid_e),
        .ctrl_e       (ctrl_e),
        .stall_e      (stall_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_md(input string tag, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_stall);
        int   stalls;
        logic bad;
        next_cycle();
        ctrl_d        = '0;
        ctrl_d.md_en  = 1'b1;
        ctrl_d.md_op  = op;
        ctrl_d.reg_write = 1'b1;
        valid_d   = 1'b1;
        rd1_d     = a;
        rd2_d     = b;
        fwd_sel_a = '0;
        fwd_sel_b = '0;
        stalls    = 0;
        bad       = 1'b0;
        @(negedge clk);
        while (stall_e && stalls < 100) begin
            stalls++;
            if (valid_e) bad = 1'b1;
            @(negedge clk);
        end
        chk({tag, " stall cycles"}, stalls, exp_stall);
        chk({tag, " valid during stall"}, {31'b0, bad}, 32'd0);
        chk({tag, " valid_e"}, {31'b0, valid_e}, 32'd1);
        chk({tag, " result"}, result_e, exp_res);
        next_cycle();
        valid_d = 1'b0;
        ctrl_d  = '0;
        @(negedge clk);
        chk({tag, " valid one cycle"}, {31'b0, valid_e}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic bad;
        rst       = 1'b1;
        valid_d   = 1'b1;
        flush_e   = 1'b0;
        pc_d      = 32'h100;
        rd1_d     = '0;
        rd2_d     = '0;
        imm_ext_d = 32'h20;
        ctrl_d    = '0;
        ctrl_d.jump = 1'b1;
        fwd_sel_a = '0;
        fwd_sel_b = '0;
        fwd_data  = {32'hAAAA0003, 32'h00000010, 32'h11111111};

        // Reset: everything quiet even with a jump presented.
        repeat (2) @(negedge clk);
        chk("rst valid_e", {31'b0, valid_e}, 32'd0);
        chk("rst stall_e", {31'b0, stall_e}, 32'd0);
        chk("rst pc_src_e", {31'b0, pc_src_e}, 32'd0);
        next_cycle();
        rst     = 1'b0;
        valid_d = 1'b0;
        ctrl_d  = '0;

        // Forwarded add.
        next_cycle();
        valid_d   = 1'b1;
        ctrl_d    = '0;
        ctrl_d.alu_control = ALU_ADD;
        fwd_sel_a = 2'd2;
        fwd_sel_b = 2'd0;
        rd2_d     = 32'd5;
        imm_ext_d = 32'h100;
        @(negedge clk);
        chk("fwd add result", result_e, 32'h15);
        chk("fwd add valid", {31'b0, valid_e}, 32'd1);
        chk("fwd add stall", {31'b0, stall_e}, 32'd0);
        chk("fwd add store data", write_data_e, 32'd5);
        chk("fwd add data_addr", data_addr, 32'h110);

        // Sub with slot 1 and slot 3 forwarded.
        next_cycle();
        ctrl_d.alu_control = ALU_SUB;
        fwd_sel_a = 2'd1;
        fwd_sel_b = 2'd3;
        @(negedge clk);
        chk("fwd sub result", result_e, 32'h6667110E);
        chk("fwd sub store data", write_data_e, 32'hAAAA0003);

        // Arithmetic shift with immediate.
        next_cycle();
        ctrl_d.alu_control = ALU_SRA;
        ctrl_d.alu_src = 1'b1;
        fwd_sel_a = 2'd0;
        rd1_d     = 32'h80000000;
        imm_ext_d = 32'd4;
        @(negedge clk);
        chk("sra result", result_e, 32'hF8000000);

        // auipc-style: PC as operand A.
        next_cycle();
        ctrl_d.alu_control = ALU_ADD;
        ctrl_d.a_sel_pc = 1'b1;
        pc_d      = 32'h200;
        imm_ext_d = 32'h34;
        @(negedge clk);
        chk("pc add result", result_e, 32'h234);

        // Flushed ALU op.
        next_cycle();
        flush_e = 1'b1;
        @(negedge clk);
        chk("alu flush valid", {31'b0, valid_e}, 32'd0);
        next_cycle();
        flush_e = 1'b0;
        valid_d = 1'b0;
        ctrl_d  = '0;

        // Multiply / divide.
        run_md("mulhu", MD_MULHU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 3);
        run_md("mul", MD_MUL, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 3);
        run_md("mulh", MD_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 3);
        run_md("mulhsu", MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 3);
        run_md("div 7/-2", MD_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        run_md("rem 7/-2", MD_REM, 32'd7, 32'hFFFFFFFE, 32'h00000001, 33);
        run_md("div -7/2", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        run_md("rem -7/2", MD_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        run_md("div ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_md("rem ovf", MD_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        run_md("divu by 0", MD_DIVU, 32'd100, 32'd0, 32'hFFFFFFFF, 1);
        run_md("remu by 0", MD_REMU, 32'd100, 32'd0, 32'd100, 1);
        run_md("divu big", MD_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 33);
        run_md("remu big", MD_REMU, 32'hFFFFFFF7, 32'h10, 32'h00000007, 33);
        run_md("divu 3/10", MD_DIVU, 32'd3, 32'd10, 32'd0, EARLY_STALL);

        // Divide flushed on its 10th stall cycle.
        next_cycle();
        ctrl_d       = '0;
        ctrl_d.md_en = 1'b1;
        ctrl_d.md_op = MD_DIV;
        valid_d      = 1'b1;
        rd1_d        = 32'd100;
        rd2_d        = 32'd7;
        bad          = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (!stall_e || valid_e) bad = 1'b1;
        end
        chk("flush pre stall", {31'b0, bad}, 32'd0);
        next_cycle();
        flush_e = 1'b1;
        @(negedge clk);
        chk("flush stall_e", {31'b0, stall_e}, 32'd0);
        chk("flush valid_e", {31'b0, valid_e}, 32'd0);
        next_cycle();
        flush_e = 1'b0;
        valid_d = 1'b0;
        ctrl_d  = '0;
        bad     = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (valid_e || stall_e) bad = 1'b1;
        end
        chk("flush no late result", {31'b0, bad}, 32'd0);
        run_md("mul after flush", MD_MUL, 32'd6, 32'd7, 32'd42, 3);

        // Branches and jumps.
        next_cycle();
        ctrl_d = '0;
        ctrl_d.alu_control = ALU_SLTU;
        ctrl_d.branch = 1'b1;
        valid_d   = 1'b1;
        rd1_d     = 32'd1;
        rd2_d     = 32'hFFFFFFFF;
        pc_d      = 32'h100;
        imm_ext_d = 32'h20;
        @(negedge clk);
        chk("bltu taken", {31'b0, pc_src_e}, 32'd1);
        chk("bltu target", pc_target_e, 32'h120);

        next_cycle();
        ctrl_d.funct3_0 = 1'b1;
        @(negedge clk);
        chk("bgeu not taken", {31'b0, pc_src_e}, 32'd0);

        next_cycle();
        ctrl_d.funct3_0 = 1'b0;
        ctrl_d.alu_control = ALU_SLT;
        @(negedge clk);
        chk("blt signed not taken", {31'b0, pc_src_e}, 32'd0);

        next_cycle();
        ctrl_d.alu_control = ALU_SUB;
        rd1_d = 32'd5;
        rd2_d = 32'd5;
        @(negedge clk);
        chk("beq taken", {31'b0, pc_src_e}, 32'd1);

        next_cycle();
        ctrl_d = '0;
        ctrl_d.jump = 1'b1;
        ctrl_d.jalr = 1'b1;
        rd1_d     = 32'h203;
        imm_ext_d = 32'h10;
        @(negedge clk);
        chk("jalr taken", {31'b0, pc_src_e}, 32'd1);
        chk("jalr target", pc_target_e, 32'h212);

        next_cycle();
        ctrl_d = '0;
        ctrl_d.alu_control = ALU_SLTU;
        ctrl_d.branch = 1'b1;
        rd1_d     = 32'd1;
        rd2_d     = 32'hFFFFFFFF;
        imm_ext_d = 32'h20;
        rst       = 1'b1;
        @(negedge clk);
        chk("bltu under rst", {31'b0, pc_src_e}, 32'd0);
        next_cycle();
        rst     = 1'b0;
        valid_d = 1'b0;
        ctrl_d  = '0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exec_md_stage.md
Name: exec_md_stage

Overview:
Parametrised execute stage for the RV32IM pipeline: forwarding muxes, single-cycle ALU, branch/jump resolution, plus an iterative multiply/divide unit that stalls the front end while busy. Sits between the decode/exec and exec/mem pipeline registers. The ALU path is combinational; the M-extension path is a sequential FSM that holds the stage via stall_e.

Parameters:
XLEN, 32, datapath width (even, >=8)
NUM_FWD, 3, number of bypass sources on fwd_data (selector 0 = register file)
MUL_LATENCY, 2, multiplier pipeline depth in cycles (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_d  in  1  instruction present at stage input
flush_e  in  1  kill the instruction at/inside this stage
pc_d  in  XLEN  instruction PC
rd1_d  in  XLEN  register-file operand A
rd2_d  in  XLEN  register-file operand B
imm_ext_d  in  XLEN  sign-extended immediate
ctrl_d  in  exec_ctrl_t  packed control: alu_control[3:0], alu_src, a_sel_pc, md_en, md_op[2:0], branch, jump, jalr, funct3_0, reg_write, result_src, mem_write, rd[4:0]
fwd_sel_a  in  $clog2(NUM_FWD+1)  operand-A source select
fwd_sel_b  in  $clog2(NUM_FWD+1)  operand-B source select
fwd_data  in  NUM_FWD*XLEN  bypass values, slot k at [k*XLEN-1 -: XLEN]
result_e  out  XLEN  ALU or M-unit result
write_data_e  out  XLEN  forwarded operand B (store data)
data_addr  out  XLEN  src_a + imm_ext_d
pc_target_e  out  XLEN  branch/jump target
pc_src_e  out  1  redirect fetch
valid_e  out  1  result_e/ctrl_e valid this cycle
ctrl_e  out  exec_ctrl_t  ctrl_d passed through
stall_e  out  1  hold fetch/decode and the decode/exec register

Behaviour:
- Forward select 0 -> rd1_d/rd2_d; k in 1..NUM_FWD -> slot k; out-of-range -> 0. src_a = a_sel_pc ? pc_d : fwd_a; src_b = alu_src ? imm_ext_d : fwd_b; write_data_e = fwd_b.
- ALU ops (md_en=0): result_e, valid_e = valid_d & ~flush_e in the same cycle; stall_e=0.
- Branch: beq/bne via zero flag, blt/bge signed less-than, bltu/bgeu unsigned less-than, inverted by funct3_0. pc_target_e = jalr ? (src_a+imm)&~1 : pc_d+imm. pc_src_e = valid_d & ~flush_e & ~rst & ((branch & met) | jump); never X.
- M-unit FSM states IDLE, MUL, DIV, DONE. IDLE with valid_d & md_en & ~flush_e: latch operands/md_op, stall_e=1, valid_e=0; go MUL (md_op[2]=0), DONE (divide special case), else DIV.
- MUL: 2*XLEN-bit product of sign/zero-extended operands per md_op (mul low, mulh/mulhsu/mulhu high); MUL_LATENCY cycles, stall_e=1.
- DIV: radix-2 restoring on magnitudes, XLEN cycles, stall_e=1; signs fixed after: quotient negative iff operand signs differ, remainder takes dividend sign.
- Special cases, no DIV cycles: divisor 0 -> quotient all-ones, remainder = dividend; signed most-negative / -1 -> quotient = dividend, remainder 0.
- DONE: one cycle, result_e = selected M result, valid_e=1, stall_e=0, -> IDLE unconditionally; the same instruction still on valid_d never restarts.
- Total stall cycles: MUL 1+MUL_LATENCY; DIV 1+XLEN; special case 1.
- flush_e in MUL/DIV/DONE: stall_e=0 and valid_e=0 that cycle; FSM -> IDLE next edge; partial results discarded.
- rst (synchronous): FSM IDLE, counters and operand registers 0. While rst is high: valid_e=0, stall_e=0, pc_src_e=0. Reset mid-operation aborts like flush.

Optional Feature:
EXEC_DIV_EARLY_OUT_EN: if the dividend magnitude is less than the divisor magnitude (divisor non-zero), the start cycle goes straight to DONE with quotient 0 and remainder = dividend, giving a 1-cycle stall.
Undefined: such divides run the full XLEN iterations with an identical result.

Decomposition:
Package exec_pkg: exec_ctrl_t struct, alu_op_e (4-bit ALU codes), md_op_e (RV32M funct3), md_state_e, branch condition codes.
One natural sub-module, md_unit: FSM, multiplier pipeline, divider, special-case logic. Start/flush in, result/done/busy out. The stage top keeps the muxes, ALU and branch logic.

Test Plan:
- fwd_sel_a=2 with slot 2=0x10, rd2_d=5, add, alu_src=0 -> result_e=0x15 and valid_e=1 the same cycle, stall_e=0.
- mulhu 0xFFFFFFFF x 2 -> stall_e high 3 cycles, then result_e=0x00000001 with valid_e for exactly 1 cycle.
- div 7 / -2 -> 0xFFFFFFFD after a 33-cycle stall; rem 7 / -2 -> 1; div 0x80000000 / -1 -> 0x80000000 after a 1-cycle stall.
- divu 100 / 0 -> 0xFFFFFFFF; remu -> 100; stall 1 cycle. With EXEC_DIV_EARLY_OUT_EN, divu 3 / 10 -> 0 after a 1-cycle stall.
- div started, flush_e asserted on stall cycle 10 -> stall_e=0 that cycle, valid_e never asserted; a following mul completes correctly.
- bltu 1 vs 0xFFFFFFFF, funct3_0=0, pc=0x100, imm=0x20 -> pc_src_e=1, pc_target_e=0x120; same stimulus with rst=1 -> pc_src_e=0.
